// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one external combinational integer ALU between two requesters.
//
// Arbitrates between port 0 (execute stage) and port 1 (address/branch helper).
// Round-robin when RR_EN=1, fixed priority to port 0 when RR_EN=0. Registers the
// winner's operands into the ALU, captures result and zero flag one cycle later,
// and holds the response until the granted port consumes it. One transaction in
// flight at a time; best case one operation every three cycles.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   reqN_valid/op/a/b (in)     request N handshake and payload (N = 0, 1)
//   reqN_ready (out)           request N accepted this cycle (combinational, IDLE only)
//   alu_a/alu_b/alu_ctrl (out) registered operands and control code to the ALU
//   alu_result/alu_zero (in)   ALU outputs
//   rspN_valid (out)           response held for port N (registered level)
//   rspN_ready (in)            port N consumes the response
//   rsp_result/rsp_zero (out)  captured result and zero flag, shared by both ports
module alu_arbiter #(
  parameter int unsigned WIDTH = 32,
  parameter bit          RR_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,

  input  logic             req0_valid,
  input  logic [3:0]       req0_op,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  output logic             req0_ready,

  input  logic             req1_valid,
  input  logic [3:0]       req1_op,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic             req1_ready,

  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [3:0]       alu_ctrl,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_zero,

  output logic             rsp0_valid,
  input  logic             rsp0_ready,
  output logic             rsp1_valid,
  input  logic             rsp1_ready,
  output logic [WIDTH-1:0] rsp_result,
  output logic             rsp_zero
);

  typedef enum logic [1:0] {StIdle, StExec, StResp} state_e;

  state_e     state_q, state_d;
  logic       last_q;       // port granted most recently
  logic       gnt_q;        // port owning the in-flight transaction
  logic [1:0] rsp_valid_q;  // one-hot per port
  logic       win;          // port that would win in this cycle
  logic       grant;
  logic       rsp_hs;

  // Winner selection. Only meaningful when at least one request is valid.
  always_comb begin
    win = 1'b0;
    if (req0_valid && req1_valid) begin
      win = RR_EN ? ~last_q : 1'b0;
    end else if (req1_valid) begin
      win = 1'b1;
    end
  end

  // Ready is gated by rst_n so nothing is reported as accepted while held in reset.
  always_comb begin
    req0_ready = rst_n && (state_q == StIdle) && req0_valid && !win;
    req1_ready = rst_n && (state_q == StIdle) && req1_valid && win;
    grant      = req0_ready || req1_ready;
    rsp_hs     = (rsp_valid_q[0] && rsp0_ready) || (rsp_valid_q[1] && rsp1_ready);
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (grant)  state_d = StExec;
      StExec:              state_d = StResp;
      StResp:  if (rsp_hs) state_d = StIdle;
      default:             state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      last_q      <= 1'b1;
      gnt_q       <= 1'b0;
      rsp_valid_q <= 2'b00;
      alu_a       <= '0;
      alu_b       <= '0;
      alu_ctrl    <= '0;
      rsp_result  <= '0;
      rsp_zero    <= 1'b0;
    end else begin
      state_q <= state_d;
      // Operands change only on a grant; they stay stable through EXEC and RESP.
      if (grant) begin
        alu_ctrl <= win ? req1_op : req0_op;
        alu_a    <= win ? req1_a  : req0_a;
        alu_b    <= win ? req1_b  : req0_b;
        gnt_q    <= win;
        last_q   <= win;
      end
      if (state_q == StExec) begin
        rsp_result  <= alu_result;
        rsp_zero    <= alu_zero;
        rsp_valid_q <= gnt_q ? 2'b10 : 2'b01;
      end else if (rsp_hs) begin
        rsp_valid_q <= 2'b00;
      end
    end
  end

  assign rsp0_valid = rsp_valid_q[0];
  assign rsp1_valid = rsp_valid_q[1];

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: directed table, hand-written corner sequences,
// and a randomized run checked against a transaction-level reference model.
module tb_alu_arbiter;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  always #5 clk = ~clk;

  logic         req0_valid = 0, req1_valid = 0;
  logic [3:0]   req0_op = 0, req1_op = 0;
  logic [W-1:0] req0_a = 0, req0_b = 0, req1_a = 0, req1_b = 0;
  logic         req0_ready, req1_ready;
  logic [W-1:0] alu_a, alu_b, alu_result;
  logic [3:0]   alu_ctrl;
  logic         alu_zero;
  logic         rsp0_valid, rsp1_valid;
  logic         rsp0_ready = 0, rsp1_ready = 0;
  logic [W-1:0] rsp_result;
  logic         rsp_zero;

  // Fixed-priority instance sharing the request inputs, responses always consumed.
  logic         fp_req0_ready, fp_req1_ready;
  logic [W-1:0] fp_alu_a, fp_alu_b, fp_alu_result, fp_rsp_result;
  logic [3:0]   fp_alu_ctrl;
  logic         fp_alu_zero, fp_rsp0_valid, fp_rsp1_valid, fp_rsp_zero;
  logic         fp_rsp_ready = 1'b1;

  int n_tests = 0;
  int n_fail  = 0;

  // Environment ALU (also used by the reference model to predict results).
  function automatic logic [W-1:0] alu_fn(input logic [3:0] op, input logic [W-1:0] a,
                                          input logic [W-1:0] b);
    logic signed [W-1:0] sa, sb;
    sa = a;
    sb = b;
    case (op)
      4'd0:    return a + b;
      4'd1:    return a - b;
      4'd2:    return a ^ b;
      4'd3:    return a & b;
      4'd4:    return a | b;
      4'd5:    return a << b[4:0];
      4'd6:    return a >> b[4:0];
      4'd7:    return sa >>> b[4:0];
      4'd8:    return (sa < sb) ? 32'd1 : 32'd0;
      4'd9:    return (a < b) ? 32'd1 : 32'd0;
      default: return '0;
    endcase
  endfunction

  always_comb begin
    alu_result    = alu_fn(alu_ctrl, alu_a, alu_b);
    alu_zero      = (alu_result == '0);
    fp_alu_result = alu_fn(fp_alu_ctrl, fp_alu_a, fp_alu_b);
    fp_alu_zero   = (fp_alu_result == '0);
  end

  alu_arbiter #(.WIDTH(W), .RR_EN(1'b1)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_op(req0_op), .req0_a(req0_a), .req0_b(req0_b),
    .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_op(req1_op), .req1_a(req1_a), .req1_b(req1_b),
    .req1_ready(req1_ready),
    .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl),
    .alu_result(alu_result), .alu_zero(alu_zero),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
    .rsp_result(rsp_result), .rsp_zero(rsp_zero)
  );

  alu_arbiter #(.WIDTH(W), .RR_EN(1'b0)) dut_fp (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_op(req0_op), .req0_a(req0_a), .req0_b(req0_b),
    .req0_ready(fp_req0_ready),
    .req1_valid(req1_valid), .req1_op(req1_op), .req1_a(req1_a), .req1_b(req1_b),
    .req1_ready(fp_req1_ready),
    .alu_a(fp_alu_a), .alu_b(fp_alu_b), .alu_ctrl(fp_alu_ctrl),
    .alu_result(fp_alu_result), .alu_zero(fp_alu_zero),
    .rsp0_valid(fp_rsp0_valid), .rsp0_ready(fp_rsp_ready),
    .rsp1_valid(fp_rsp1_valid), .rsp1_ready(fp_rsp_ready),
    .rsp_result(fp_rsp_result), .rsp_zero(fp_rsp_zero)
  );

  task automatic chk32(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b, expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input bit port, input logic v, input logic [3:0] op,
                         input logic [W-1:0] a, input logic [W-1:0] b);
    if (port) begin
      req1_valid = v; req1_op = op; req1_a = a; req1_b = b;
    end else begin
      req0_valid = v; req0_op = op; req0_a = a; req0_b = b;
    end
  endtask

  task automatic set_rsp_ready(input bit port, input logic v);
    if (port) rsp1_ready = v;
    else      rsp0_ready = v;
  endtask

  task automatic chk_all_zero(input string name);
    chk32({name, "_alu_a"}, alu_a, '0);
    chk32({name, "_alu_b"}, alu_b, '0);
    chk32({name, "_alu_ctrl"}, {28'd0, alu_ctrl}, '0);
    chk1({name, "_req0_ready"}, req0_ready, 1'b0);
    chk1({name, "_req1_ready"}, req1_ready, 1'b0);
    chk1({name, "_rsp0_valid"}, rsp0_valid, 1'b0);
    chk1({name, "_rsp1_valid"}, rsp1_valid, 1'b0);
    chk32({name, "_rsp_result"}, rsp_result, '0);
    chk1({name, "_rsp_zero"}, rsp_zero, 1'b0);
  endtask

  // Starts at posedge+1 with the arbiter idle; ends at the negedge after the handshake.
  task automatic run_txn(input bit port, input logic [3:0] op, input logic [W-1:0] a,
                         input logic [W-1:0] b, output logic [W-1:0] res, output logic z);
    bit got;
    got = 0;
    set_req(port, 1'b1, op, a, b);
    for (int n = 0; n < 10 && !got; n++) begin
      @(negedge clk);
      if ((port ? req1_ready : req0_ready) === 1'b1) got = 1;
      else tick();
    end
    chk1("txn_grant", got, 1'b1);
    chk1("txn_other_ready", port ? req0_ready : req1_ready, 1'b0);
    tick();
    set_req(port, 1'b0, 4'd0, '0, '0);
    @(negedge clk);
    chk32("txn_alu_ctrl", {28'd0, alu_ctrl}, {28'd0, op});
    chk32("txn_alu_a", alu_a, a);
    chk32("txn_alu_b", alu_b, b);
    chk1("txn_exec_no_rsp", rsp0_valid | rsp1_valid, 1'b0);
    tick();
    @(negedge clk);
    chk1("txn_rsp_valid", port ? rsp1_valid : rsp0_valid, 1'b1);
    chk1("txn_rsp_other", port ? rsp0_valid : rsp1_valid, 1'b0);
    res = rsp_result;
    z   = rsp_zero;
    set_rsp_ready(port, 1'b1);
    tick();
    set_rsp_ready(port, 1'b0);
    @(negedge clk);
    chk1("txn_rsp_cleared", port ? rsp1_valid : rsp0_valid, 1'b0);
  endtask

  task automatic pulse_reset();
    @(posedge clk);
    #1 rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  typedef struct {
    bit           port;
    logic [3:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] exp_res;
    logic         exp_zero;
  } vec_t;

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1, "timeout");
  end

  initial begin : main
    vec_t         vecs[10];
    logic [W-1:0] res;
    logic         z;
    int           grant_port[$];
    int           grant_cyc[$];
    int           fp_grants;

    vecs[0] = '{0, 4'b0000, 32'd5,          32'd7,  32'd12,         1'b0};
    vecs[1] = '{1, 4'b0001, 32'd9,          32'd9,  32'd0,          1'b1};
    vecs[2] = '{0, 4'b0011, 32'hF0,         32'h3C, 32'h30,         1'b0};
    vecs[3] = '{1, 4'b0100, 32'hF0,         32'h0F, 32'hFF,         1'b0};
    vecs[4] = '{0, 4'b0111, 32'h8000_0000,  32'd4,  32'hF800_0000,  1'b0};
    vecs[5] = '{1, 4'b1000, 32'hFFFF_FFFF,  32'd1,  32'd1,          1'b0};
    vecs[6] = '{0, 4'b1010, 32'h1234,       32'h56, 32'd0,          1'b1};
    vecs[7] = '{1, 4'b1111, 32'd1,          32'd1,  32'd0,          1'b1};
    vecs[8] = '{0, 4'b0001, 32'd3,          32'd5,  32'hFFFF_FFFE,  1'b0};
    vecs[9] = '{1, 4'b0000, 32'hFFFF_FFFF,  32'd1,  32'd0,          1'b1};

    // Reset state.
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_all_zero("reset");
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Directed table; the first entry is the single-add latency case.
    for (int i = 0; i < 10; i++) begin
      run_txn(vecs[i].port, vecs[i].op, vecs[i].a, vecs[i].b, res, z);
      chk32($sformatf("vec%0d_result", i), res, vecs[i].exp_res);
      chk1($sformatf("vec%0d_zero", i), z, vecs[i].exp_zero);
      tick();
    end

    // Response backpressure: rsp0 stalls while req1 waits.
    set_req(0, 1'b1, 4'd0, 32'd1, 32'd2);
    @(negedge clk);
    chk1("bp_grant0", req0_ready, 1'b1);
    tick();
    set_req(0, 1'b0, 4'd0, '0, '0);
    @(negedge clk);
    tick();
    @(negedge clk);
    chk1("bp_rsp0_valid", rsp0_valid, 1'b1);
    tick();
    set_req(1, 1'b1, 4'd4, 32'hA, 32'h5);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk1("bp_hold_valid", rsp0_valid, 1'b1);
      chk32("bp_hold_result", rsp_result, 32'd3);
      chk32("bp_hold_alu_a", alu_a, 32'd1);
      chk32("bp_hold_alu_b", alu_b, 32'd2);
      chk32("bp_hold_ctrl", {28'd0, alu_ctrl}, 32'd0);
      chk1("bp_no_req1_ready", req1_ready, 1'b0);
      tick();
    end
    rsp0_ready = 1'b1;
    @(negedge clk);
    chk1("bp_hs_cycle_req1_ready", req1_ready, 1'b0);
    tick();
    rsp0_ready = 1'b0;
    @(negedge clk);
    chk1("bp_rsp0_dropped", rsp0_valid, 1'b0);
    chk1("bp_req1_granted", req1_ready, 1'b1);
    tick();
    set_req(1, 1'b0, 4'd0, '0, '0);
    @(negedge clk);
    chk32("bp_req1_ctrl", {28'd0, alu_ctrl}, 32'd4);
    tick();
    @(negedge clk);
    chk1("bp_rsp1_valid", rsp1_valid, 1'b1);
    chk32("bp_rsp1_result", rsp_result, 32'hF);
    rsp1_ready = 1'b1;
    tick();
    rsp1_ready = 1'b0;

    // Reset during EXEC, then contention after release.
    set_req(0, 1'b1, 4'd0, 32'd100, 32'd200);
    @(negedge clk);
    chk1("rst_pre_grant", req0_ready, 1'b1);
    tick();
    set_req(1, 1'b1, 4'd1, 32'd50, 32'd8);
    #2 rst_n = 1'b0;
    #1;
    chk_all_zero("rst_async");
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk1("rst_after_req0_wins", req0_ready, 1'b1);
    chk1("rst_after_req1_waits", req1_ready, 1'b0);
    tick();
    set_req(0, 1'b0, 4'd0, '0, '0);
    @(negedge clk);
    chk32("rst_after_alu_a", alu_a, 32'd100);
    tick();
    @(negedge clk);
    chk1("rst_after_rsp0", rsp0_valid, 1'b1);
    chk32("rst_after_res0", rsp_result, 32'd300);
    rsp0_ready = 1'b1;
    tick();
    rsp0_ready = 1'b0;
    @(negedge clk);
    chk1("rst_after_req1_granted", req1_ready, 1'b1);
    tick();
    set_req(1, 1'b0, 4'd0, '0, '0);
    tick();
    @(negedge clk);
    chk1("rst_after_rsp1", rsp1_valid, 1'b1);
    chk32("rst_after_res1", rsp_result, 32'd42);
    rsp1_ready = 1'b1;
    tick();
    rsp1_ready = 1'b0;

    // Continuous contention with responses always consumed.
    pulse_reset();
    rsp0_ready = 1'b1;
    rsp1_ready = 1'b1;
    set_req(0, 1'b1, 4'b0011, 32'hF0, 32'h3C);
    set_req(1, 1'b1, 4'b0100, 32'hF0, 32'h0F);
    fp_grants = 0;
    for (int c = 0; c < 15; c++) begin
      @(negedge clk);
      if (req0_ready) begin grant_port.push_back(0); grant_cyc.push_back(c); end
      if (req1_ready) begin grant_port.push_back(1); grant_cyc.push_back(c); end
      if (rsp0_valid) chk32("rr_res0", rsp_result, 32'h30);
      if (rsp1_valid) chk32("rr_res1", rsp_result, 32'hFF);
      if (fp_req0_ready) fp_grants++;
      if (fp_req1_ready) chk1("fp_never_grants_p1", fp_req1_ready, 1'b0);
      if (fp_rsp0_valid) chk32("fp_res0", fp_rsp_result, 32'h30);
      tick();
    end
    chk32("rr_grant_count", (grant_port.size() >= 4) ? 32'd1 : 32'd0, 32'd1);
    chk32("fp_grant_count", (fp_grants >= 4) ? 32'd1 : 32'd0, 32'd1);
    if (grant_port.size() >= 4) begin
      for (int i = 0; i < 4; i++) begin
        chk32($sformatf("rr_grant%0d", i), grant_port[i], i % 2);
        if (i > 0) chk32($sformatf("rr_gap%0d", i), grant_cyc[i] - grant_cyc[i-1], 32'd3);
      end
    end
    set_req(0, 1'b0, 4'd0, '0, '0);
    set_req(1, 1'b0, 4'd0, '0, '0);
    repeat (4) tick();
    rsp0_ready = 1'b0;
    rsp1_ready = 1'b0;

    // Randomized run against a transaction-level model.
    pulse_reset();
    begin : rand_run
      int           phase;      // 0 free, 1 operands presented, 2 response owed
      bit           m_last;
      bit           m_port;
      logic [3:0]   m_op;
      logic [W-1:0] m_a, m_b, m_res;
      bit           acc0, acc1, exp0, exp1;
      phase = 0; m_last = 1; m_port = 0; m_op = 0; m_a = 0; m_b = 0;
      acc0 = 0; acc1 = 0;
      for (int cyc = 0; cyc < 600; cyc++) begin
        for (int p = 0; p < 2; p++) begin
          logic v;
          logic acc;
          v   = (p == 0) ? req0_valid : req1_valid;
          acc = (p == 0) ? acc0 : acc1;
          if (!(v && !acc)) begin
            if ($urandom_range(0, 2) == 0)
              set_req(p[0], 1'b1, 4'($urandom_range(0, 15)),
                      ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 3)) : W'($urandom()),
                      ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 3)) : W'($urandom()));
            else
              set_req(p[0], 1'b0, 4'd0, '0, '0);
          end
        end
        rsp0_ready = 1'($urandom_range(0, 1));
        rsp1_ready = 1'($urandom_range(0, 1));
        @(negedge clk);
        acc0 = 0; acc1 = 0;
        exp0 = 0; exp1 = 0;
        if (phase == 0) begin
          if (req0_valid && req1_valid) begin
            exp0 = (m_last == 1);
            exp1 = (m_last == 0);
          end else begin
            exp0 = req0_valid;
            exp1 = req1_valid;
          end
        end
        chk1("rand_req0_ready", req0_ready, exp0);
        chk1("rand_req1_ready", req1_ready, exp1);
        case (phase)
          0: begin
            chk1("rand_idle_rsp", rsp0_valid | rsp1_valid, 1'b0);
            if (exp0 || exp1) begin
              m_port = exp1;
              m_op   = exp1 ? req1_op : req0_op;
              m_a    = exp1 ? req1_a  : req0_a;
              m_b    = exp1 ? req1_b  : req0_b;
              m_last = m_port;
              if (exp1) acc1 = 1; else acc0 = 1;
              phase  = 1;
            end
          end
          1: begin
            chk32("rand_alu_ctrl", {28'd0, alu_ctrl}, {28'd0, m_op});
            chk32("rand_alu_a", alu_a, m_a);
            chk32("rand_alu_b", alu_b, m_b);
            chk1("rand_exec_rsp", rsp0_valid | rsp1_valid, 1'b0);
            phase = 2;
          end
          default: begin
            m_res = alu_fn(m_op, m_a, m_b);
            chk1("rand_rsp_valid", m_port ? rsp1_valid : rsp0_valid, 1'b1);
            chk1("rand_rsp_other", m_port ? rsp0_valid : rsp1_valid, 1'b0);
            chk32("rand_rsp_result", rsp_result, m_res);
            chk1("rand_rsp_zero", rsp_zero, m_res == '0);
            chk32("rand_alu_hold", alu_a, m_a);
            if ((m_port ? rsp1_ready : rsp0_ready) == 1'b1) phase = 0;
          end
        endcase
        tick();
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
